// File: rtl/fsm3_pkg.sv
// fsm3_pkg: constants and types shared by the 3-cycle pulse line generator
// and decoder.
//   state_e     : decoder FSM states (IDLE, HIGH, LOW)
//   RUN_BIT0/1  : high-run lengths that encode bit 0 / bit 1
//   RUN_CNT_W   : width of the run/gap counters; RUN_CNT_MAX is their ceiling
package fsm3_pkg;
  localparam int                   RUN_CNT_W   = 3;
  localparam logic [RUN_CNT_W-1:0] RUN_CNT_MAX = 3'd7;
  localparam logic [RUN_CNT_W-1:0] RUN_BIT0    = 3'd1;
  localparam logic [RUN_CNT_W-1:0] RUN_BIT1    = 3'd3;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

  // A run is a valid symbol only if its length is one of the two encodings.
  function automatic logic run_is_good(input logic [RUN_CNT_W-1:0] cnt);
    return (cnt == RUN_BIT0) || (cnt == RUN_BIT1);
  endfunction
endpackage

// File: rtl/fsm3_run_counter.sv
// fsm3_run_counter: saturating up-counter for run and gap lengths.
//   clk, rst : clock, synchronous active-low reset
//   i_load1  : restart the count at 1 (first sample of a new run)
//   i_inc    : add one, holding at all-ones
//   o_cnt    : current count
module fsm3_run_counter
  import fsm3_pkg::*;
#(
  parameter int W = RUN_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load1,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst)                      r_cnt <= '0;
    else if (i_load1)              r_cnt <= W'(1);
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/fsm3cycles_decoder.sv
// fsm3cycles_decoder: pulse-width decoder / deserializer for the 3-cycle
// pulse line. A 1-cycle high run is bit 0, a 3-cycle run is bit 1, anything
// else is an error that discards the partial word. Words are LSB-first.
//   clk, rst   : clock, synchronous active-low reset
//   line_in    : pulse line, same clock domain as the generator
//   bit_valid  : 1-cycle strobe, bit_out holds the decoded bit
//   word_valid : 1-cycle strobe, word_out holds a complete word (held after)
//   err        : 1-cycle strobe, malformed symbol (or framing gap)
// Build option: FSM3_STRICT_GAP_EN makes a low gap longer than one cycle
// inside a partly assembled word a framing error.
module fsm3cycles_decoder
  import fsm3_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_in,
  output logic              bit_valid,
  output logic              bit_out,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              err
);
  localparam int               IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
`ifdef FSM3_STRICT_GAP_EN
  localparam bit STRICT_GAP = 1'b1;
`else
  localparam bit STRICT_GAP = 1'b0;
`endif

  state_e               r_state, w_next;
  logic [RUN_CNT_W-1:0] w_run_cnt, w_gap_cnt;
  logic                 w_run_load, w_run_inc, w_gap_load, w_gap_inc;
  logic                 w_classify, w_gap_err, w_good, w_bit;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [WORD_W-1:0]    r_word, w_word_next;
  logic                 r_bit_valid, r_bit_out, r_word_valid, r_err;
  logic [WORD_W-1:0]    r_word_out;

  fsm3_run_counter #(.W(RUN_CNT_W)) u_run_cnt (
    .clk(clk), .rst(rst), .i_load1(w_run_load), .i_inc(w_run_inc), .o_cnt(w_run_cnt)
  );
  fsm3_run_counter #(.W(RUN_CNT_W)) u_gap_cnt (
    .clk(clk), .rst(rst), .i_load1(w_gap_load), .i_inc(w_gap_inc), .o_cnt(w_gap_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_run_load = 1'b0;
    w_run_inc  = 1'b0;
    w_gap_load = 1'b0;
    w_gap_inc  = 1'b0;
    w_classify = 1'b0;
    w_gap_err  = 1'b0;
    case (r_state)
      IDLE: if (line_in) begin
        w_next     = HIGH;
        w_run_load = 1'b1;
      end
      HIGH: if (line_in) begin
        w_run_inc = 1'b1;
      end else begin
        // Falling sample closes the run: classify its length now.
        w_classify = 1'b1;
        w_gap_load = 1'b1;
        w_next     = LOW;
      end
      LOW: if (line_in) begin
        w_next     = HIGH;
        w_run_load = 1'b1;
      end else begin
        w_gap_inc = 1'b1;
        // Second low sample inside a word: gap_cnt is about to go 1->2.
        if (STRICT_GAP && r_bit_idx != '0 && w_gap_cnt == RUN_CNT_W'(1)) begin
          w_gap_err = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_good = run_is_good(w_run_cnt);
  assign w_bit  = (w_run_cnt == RUN_BIT1);

  always_comb begin
    w_word_next            = r_word;
    w_word_next[r_bit_idx] = w_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bit_valid  <= 1'b0;
      r_bit_out    <= 1'b0;
      r_word_valid <= 1'b0;
      r_word_out   <= '0;
      r_err        <= 1'b0;
      r_bit_idx    <= '0;
      r_word       <= '0;
    end else begin
      r_bit_valid  <= 1'b0;
      r_word_valid <= 1'b0;
      r_err        <= 1'b0;
      if (w_classify && w_good) begin
        r_bit_valid <= 1'b1;
        r_bit_out   <= w_bit;
        if (r_bit_idx == LAST_IDX) begin
          r_word_valid <= 1'b1;
          r_word_out   <= w_word_next;
          r_word       <= '0;
          r_bit_idx    <= '0;
        end else begin
          r_word    <= w_word_next;
          r_bit_idx <= r_bit_idx + 1'b1;
        end
      end else if (w_classify || w_gap_err) begin
        r_err     <= 1'b1;
        r_word    <= '0;
        r_bit_idx <= '0;
      end
    end
  end

  assign bit_valid  = r_bit_valid;
  assign bit_out    = r_bit_out;
  assign word_valid = r_word_valid;
  assign word_out   = r_word_out;
  assign err        = r_err;
endmodule

// File: tb/tb_fsm3cycles_decoder.sv
// Directed bench for fsm3cycles_decoder (WORD_W=8). Inputs change on the
// falling edge; outputs are checked on the falling edge after the rising
// edge that sampled the stimulus. A side monitor counts strobes.
module tb_fsm3cycles_decoder;
  logic       clk = 1'b0;
  logic       rst;
  logic       line_in;
  logic       bit_valid, bit_out, word_valid, err;
  logic [7:0] word_out;

  int checks = 0;
  int errors = 0;
  int n_bits = 0, n_words = 0, n_errs = 0, n_overlap = 0;
  logic [31:0] bit_hist = '0;
  int b_bits, b_words, b_errs, b_ovl;

  fsm3cycles_decoder #(.WORD_W(8)) dut (
    .clk(clk), .rst(rst), .line_in(line_in), .bit_valid(bit_valid),
    .bit_out(bit_out), .word_valid(word_valid), .word_out(word_out), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bit_valid) begin
      n_bits++;
      bit_hist = {bit_hist[30:0], bit_out};
    end
    if (word_valid) n_words++;
    if (err) n_errs++;
    if (err && (bit_valid || word_valid)) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v);
    line_in = v;
    @(negedge clk);
  endtask

  // One symbol: a low cycle then a 1- or 3-cycle high run.
  task automatic sym(input logic b);
    step(1'b0);
    repeat (b ? 3 : 1) step(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] w);
    for (int i = 0; i < 8; i++) sym(w[i]);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b0);
    step(1'b0);
    rst = 1'b1;
  endtask

  task automatic snap();
    b_bits = n_bits; b_words = n_words; b_errs = n_errs; b_ovl = n_overlap;
  endtask

  initial begin
    rst = 1'b0;
    line_in = 1'b0;
    @(negedge clk);

    // Reset state
    rst = 1'b0;
    step(1'b0);
    step(1'b0);
    check("rst_bit_valid", 32'(bit_valid), 32'd0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_word_out", 32'(word_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;

    // Single bit 0: 0,1,0
    step(1'b0); step(1'b1); step(1'b0);
    check("b0_valid", 32'(bit_valid), 32'd1);
    check("b0_value", 32'(bit_out), 32'd0);
    check("b0_err", 32'(err), 32'd0);
    step(1'b0);
    check("b0_strobe_width", 32'(bit_valid), 32'd0);

    // Single bit 1: 0,1,1,1,0
    do_reset();
    step(1'b0); step(1'b1); step(1'b1); step(1'b1); step(1'b0);
    check("b1_valid", 32'(bit_valid), 32'd1);
    check("b1_value", 32'(bit_out), 32'd1);
    check("b1_err", 32'(err), 32'd0);

    // Back-to-back 0xA5
    do_reset();
    snap();
    send_byte(8'hA5);
    step(1'b0);
    check("a5_word_valid", 32'(word_valid), 32'd1);
    check("a5_bit_with_word", 32'(bit_valid), 32'd1);
    check("a5_last_bit", 32'(bit_out), 32'd1);
    check("a5_word_out", 32'(word_out), 32'hA5);
    step(1'b0);
    check("a5_word_strobe_width", 32'(word_valid), 32'd0);
    check("a5_word_hold", 32'(word_out), 32'hA5);
    check("a5_bit_count", 32'(n_bits - b_bits), 32'd8);
    check("a5_word_count", 32'(n_words - b_words), 32'd1);
    check("a5_bit_order", 32'(bit_hist[7:0]), 32'b1010_0101);
    check("a5_err_count", 32'(n_errs - b_errs), 32'd0);

    // 3 good bits, bad 2-cycle run, then 0x3C
    do_reset();
    check("reset_clears_word_out", 32'(word_out), 32'd0);
    snap();
    sym(1'b1); sym(1'b1); sym(1'b0);
    step(1'b0); step(1'b1); step(1'b1);
    step(1'b0);
    check("bad2_err", 32'(err), 32'd1);
    check("bad2_no_bit", 32'(bit_valid), 32'd0);
    send_byte(8'h3C);
    step(1'b0);
    check("3c_word_valid", 32'(word_valid), 32'd1);
    check("3c_word_out", 32'(word_out), 32'h3C);
    check("3c_err_count", 32'(n_errs - b_errs), 32'd1);
    check("3c_word_count", 32'(n_words - b_words), 32'd1);
    check("3c_bit_count", 32'(n_bits - b_bits), 32'd11);
    check("3c_overlap", 32'(n_overlap - b_ovl), 32'd0);

    // 10-cycle high run saturates the run counter
    do_reset();
    snap();
    step(1'b0);
    repeat (10) step(1'b1);
    check("sat_run_cnt", 32'(dut.w_run_cnt), 32'd7);
    step(1'b0);
    check("sat_err", 32'(err), 32'd1);
    check("sat_no_bit", 32'(bit_valid), 32'd0);
    step(1'b0);
    check("sat_err_width", 32'(err), 32'd0);
    check("sat_err_count", 32'(n_errs - b_errs), 32'd1);
    check("sat_bit_count", 32'(n_bits - b_bits), 32'd0);

    // 4 bits, 3-cycle low gap, 4 more bits (word = 0x69 LSB-first)
    do_reset();
    snap();
    sym(1'b1); sym(1'b0); sym(1'b0); sym(1'b1);
    step(1'b0);
    step(1'b0);
`ifdef FSM3_STRICT_GAP_EN
    check("gap_err", 32'(err), 32'd1);
`else
    check("gap_err", 32'(err), 32'd0);
`endif
    step(1'b0);
    sym(1'b0); sym(1'b1); sym(1'b1); sym(1'b0);
    step(1'b0);
`ifdef FSM3_STRICT_GAP_EN
    check("gap_word_valid", 32'(word_valid), 32'd0);
    check("gap_word_count", 32'(n_words - b_words), 32'd0);
`else
    check("gap_word_valid", 32'(word_valid), 32'd1);
    check("gap_word_out", 32'(word_out), 32'h69);
    check("gap_word_count", 32'(n_words - b_words), 32'd1);
`endif

    // Reset priority over a same-cycle classification
    do_reset();
    step(1'b0); step(1'b1);
    rst = 1'b0;
    step(1'b0);
    check("rst_prio_bit_valid", 32'(bit_valid), 32'd0);
    check("rst_prio_err", 32'(err), 32'd0);
    rst = 1'b1;

    // Reset for one cycle mid-word and mid-run, then a fresh 0xC3
    do_reset();
    sym(1'b1); sym(1'b1); sym(1'b1);
    step(1'b0); step(1'b1); step(1'b1);
    rst = 1'b0;
    step(1'b1);
    check("mid_rst_bit_valid", 32'(bit_valid), 32'd0);
    check("mid_rst_bit_out", 32'(bit_out), 32'd0);
    check("mid_rst_word_valid", 32'(word_valid), 32'd0);
    check("mid_rst_word_out", 32'(word_out), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    step(1'b0);
    check("post_rst_no_strobe", 32'({bit_valid, word_valid, err}), 32'd0);
    snap();
    send_byte(8'hC3);
    step(1'b0);
    check("fresh_word_valid", 32'(word_valid), 32'd1);
    check("fresh_word_out", 32'(word_out), 32'hC3);
    check("fresh_word_count", 32'(n_words - b_words), 32'd1);
    check("fresh_bit_count", 32'(n_bits - b_bits), 32'd8);
    check("fresh_err_count", 32'(n_errs - b_errs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
